// File: rtl/dibit_pixel_receiver.sv
// Dibit-stream packet receiver: reassembles bytes from 2-bit symbols, decodes
// a 24-bit base-address header, writes pixel bytes to a wrapping frame-buffer
// address and forwards any trailing bytes as audio.
`timescale 1ns/1ps
module dibit_pixel_receiver #(
    parameter int unsigned PIXELS_PER_PKT = 320,
    parameter int unsigned FRAME_PIXELS   = 76800
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        axiiv,
    input  logic [1:0]  axiid,
    output logic        pixel_we,
    output logic [16:0] pixel_addr,
    output logic [7:0]  pixel_data,
    output logic        audio_valid,
    output logic [7:0]  audio_data,
    output logic        pkt_done,
    output logic        pkt_err
);

    localparam int unsigned ADDR_W = 17;
    localparam int unsigned SUM_W  = ADDR_W + 1;
    localparam int unsigned HDR_W  = 24;
    localparam int unsigned PCNT_W = $clog2(PIXELS_PER_PKT + 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ADDR  = 3'd1;
    localparam logic [2:0] S_PIXEL = 3'd2;
    localparam logic [2:0] S_AUDIO = 3'd3;
    localparam logic [2:0] S_DROP  = 3'd4;

    localparam logic [HDR_W-1:0]  FRAME_LIM  = HDR_W'(FRAME_PIXELS);
    localparam logic [SUM_W-1:0]  FRAME_WRAP = SUM_W'(FRAME_PIXELS);
    localparam logic [PCNT_W-1:0] LAST_PIX   = PCNT_W'(PIXELS_PER_PKT - 1);

    logic [2:0]        state, state_nxt;
    logic [1:0]        dcnt, dcnt_nxt;
    logic [1:0]        hcnt, hcnt_nxt;
    logic [PCNT_W-1:0] pcnt, pcnt_nxt;
    logic [5:0]        shreg, shreg_nxt;
    logic [15:0]       base, base_nxt;
    logic [ADDR_W-1:0] addr, addr_nxt;
    logic              armed, armed_nxt;

    logic              pixel_we_nxt;
    logic [ADDR_W-1:0] pixel_addr_nxt;
    logic [7:0]        pixel_data_nxt;
    logic              audio_valid_nxt;
    logic [7:0]        audio_data_nxt;
    logic              pkt_done_nxt;
    logic              pkt_err_nxt;

    logic [7:0]        byte_c;
    logic              byte_done_c;
    logic [HDR_W-1:0]  header_c;
    logic [SUM_W-1:0]  addr_inc_c;
    logic [ADDR_W-1:0] addr_step_c;

    // Byte under assembly, full header word, and next pixel address with wrap
    always_comb begin
        byte_c      = {axiid, shreg};
        byte_done_c = axiiv && (dcnt == 2'd3);
        header_c    = {base, byte_c};
        addr_inc_c  = {1'b0, addr} + SUM_W'(1);
        if (addr_inc_c >= FRAME_WRAP) begin
            addr_step_c = ADDR_W'(addr_inc_c - FRAME_WRAP);
        end else begin
            addr_step_c = ADDR_W'(addr_inc_c);
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state, datapath and strobe decode
    always_comb begin
        state_nxt       = state;
        dcnt_nxt        = dcnt;
        hcnt_nxt        = hcnt;
        pcnt_nxt        = pcnt;
        shreg_nxt       = shreg;
        base_nxt        = base;
        addr_nxt        = addr;
        armed_nxt       = armed | ~axiiv;
        pixel_we_nxt    = 1'b0;
        pixel_addr_nxt  = pixel_addr;
        pixel_data_nxt  = pixel_data;
        audio_valid_nxt = 1'b0;
        audio_data_nxt  = audio_data;
        pkt_done_nxt    = 1'b0;
        pkt_err_nxt     = 1'b0;

        case (state)
            S_IDLE: begin
                // After reset, a packet is only accepted once axiiv has been seen low
                if (armed && axiiv) begin
                    state_nxt = S_ADDR;
                    shreg_nxt = {axiid, shreg[5:2]};
                    dcnt_nxt  = 2'd1;
                end
            end
            S_ADDR: begin
                if (!axiiv) begin
                    pkt_err_nxt = 1'b1;
                    state_nxt   = S_IDLE;
                end else begin
                    shreg_nxt = {axiid, shreg[5:2]};
                    dcnt_nxt  = dcnt + 2'd1;
                    if (byte_done_c) begin
                        base_nxt = header_c[15:0];
                        hcnt_nxt = hcnt + 2'd1;
                        if (hcnt == 2'd2) begin
                            if (header_c < FRAME_LIM) begin
                                state_nxt = S_PIXEL;
                                addr_nxt  = header_c[ADDR_W-1:0];
                                pcnt_nxt  = '0;
                            end else begin
                                state_nxt   = S_DROP;
                                pkt_err_nxt = 1'b1;
                            end
                        end
                    end
                end
            end
            S_PIXEL: begin
                if (!axiiv) begin
                    pkt_err_nxt = 1'b1;
                    state_nxt   = S_IDLE;
                end else begin
                    shreg_nxt = {axiid, shreg[5:2]};
                    dcnt_nxt  = dcnt + 2'd1;
                    if (byte_done_c) begin
                        pixel_we_nxt   = 1'b1;
                        pixel_addr_nxt = addr;
                        pixel_data_nxt = byte_c;
                        addr_nxt       = addr_step_c;
                        pcnt_nxt       = pcnt + PCNT_W'(1);
                        if (pcnt == LAST_PIX) begin
                            state_nxt = S_AUDIO;
                        end
                    end
                end
            end
            S_AUDIO: begin
                if (!axiiv) begin
                    pkt_done_nxt = 1'b1;
                    state_nxt    = S_IDLE;
                end else begin
                    shreg_nxt = {axiid, shreg[5:2]};
                    dcnt_nxt  = dcnt + 2'd1;
                    if (byte_done_c) begin
                        audio_valid_nxt = 1'b1;
                        audio_data_nxt  = byte_c;
                    end
                end
            end
            S_DROP: begin
                if (!axiiv) begin
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase

        // Every return to IDLE realigns the byte framing for the next packet
        if (state_nxt == S_IDLE) begin
            dcnt_nxt  = '0;
            hcnt_nxt  = '0;
            pcnt_nxt  = '0;
            shreg_nxt = '0;
            base_nxt  = '0;
        end
    end

    // Datapath registers and registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dcnt        <= '0;
            hcnt        <= '0;
            pcnt        <= '0;
            shreg       <= '0;
            base        <= '0;
            addr        <= '0;
            armed       <= 1'b0;
            pixel_we    <= 1'b0;
            pixel_addr  <= '0;
            pixel_data  <= '0;
            audio_valid <= 1'b0;
            audio_data  <= '0;
            pkt_done    <= 1'b0;
            pkt_err     <= 1'b0;
        end else begin
            dcnt        <= dcnt_nxt;
            hcnt        <= hcnt_nxt;
            pcnt        <= pcnt_nxt;
            shreg       <= shreg_nxt;
            base        <= base_nxt;
            addr        <= addr_nxt;
            armed       <= armed_nxt;
            pixel_we    <= pixel_we_nxt;
            pixel_addr  <= pixel_addr_nxt;
            pixel_data  <= pixel_data_nxt;
            audio_valid <= audio_valid_nxt;
            audio_data  <= audio_data_nxt;
            pkt_done    <= pkt_done_nxt;
            pkt_err     <= pkt_err_nxt;
        end
    end

endmodule

// File: tb/tb_dibit_pixel_receiver.sv
// Directed bench for dibit_pixel_receiver: packet vector table plus
// hand-written latency and mid-packet reset sequences.
`timescale 1ns/1ps
module tb_dibit_pixel_receiver;

    localparam int FP = 76800;

    logic        clk = 1'b0;
    logic        rst;
    logic        axiiv;
    logic [1:0]  axiid;
    logic        pixel_we;
    logic [16:0] pixel_addr;
    logic [7:0]  pixel_data;
    logic        audio_valid;
    logic [7:0]  audio_data;
    logic        pkt_done;
    logic        pkt_err;

    dibit_pixel_receiver #(.PIXELS_PER_PKT(320), .FRAME_PIXELS(76800)) dut (
        .clk(clk), .rst(rst), .axiiv(axiiv), .axiid(axiid),
        .pixel_we(pixel_we), .pixel_addr(pixel_addr), .pixel_data(pixel_data),
        .audio_valid(audio_valid), .audio_data(audio_data),
        .pkt_done(pkt_done), .pkt_err(pkt_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Monitor state, cleared per packet by the stimulus process
    int         we_cnt, first_addr, last_addr, max_addr, seq_err, data_err;
    int         done_cnt, err_cnt, conflict_cnt = 0;
    logic [7:0] aud_q[$];
    logic [7:0] exp_pix_mon;
    bit         chk_data;
    logic [1:0] stim_q[$];

    typedef struct {
        string      name;
        logic [23:0] base;
        int         hdr_dibits;
        int         n_pix;
        int         part_dibits;
        logic [7:0] pix;
        int         n_aud;
        logic [7:0] aud0;
        logic [7:0] aud1;
        int         tail;
        int         exp_we;
        int         exp_first;
        int         exp_last;
        int         exp_done;
        int         exp_err;
        int         exp_aud;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic clear_mon();
        we_cnt = 0; first_addr = -1; last_addr = -1; max_addr = -1;
        seq_err = 0; data_err = 0; done_cnt = 0; err_cnt = 0;
        aud_q.delete();
    endtask

    // Sample registered outputs just after each rising edge
    always @(posedge clk) begin
        #1;
        if ((pkt_done && pkt_err) || (pixel_we && audio_valid)) conflict_cnt++;
        if (pixel_we) begin
            if (we_cnt == 0) first_addr = int'(pixel_addr);
            else if (int'(pixel_addr) != ((last_addr == FP - 1) ? 0 : last_addr + 1)) seq_err++;
            last_addr = int'(pixel_addr);
            if (int'(pixel_addr) > max_addr) max_addr = int'(pixel_addr);
            if (chk_data && pixel_data != exp_pix_mon) data_err++;
            we_cnt++;
        end
        if (audio_valid) aud_q.push_back(audio_data);
        if (pkt_done) done_cnt++;
        if (pkt_err) err_cnt++;
    end

    task automatic push_byte(input logic [7:0] b);
        for (int i = 0; i < 4; i++) stim_q.push_back(b[2*i +: 2]);
    endtask

    task automatic send_dibit(input logic [1:0] d);
        @(negedge clk);
        axiiv = 1'b1;
        axiid = d;
    endtask

    task automatic send_q();
        foreach (stim_q[i]) send_dibit(stim_q[i]);
        stim_q.delete();
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            axiiv = 1'b0;
            axiid = 2'b00;
        end
    endtask

    task automatic run_vec(input vec_t v);
        clear_mon();
        exp_pix_mon = v.pix;
        chk_data    = 1'b1;
        stim_q.delete();
        push_byte(v.base[23:16]);
        push_byte(v.base[15:8]);
        push_byte(v.base[7:0]);
        while (stim_q.size() > v.hdr_dibits) void'(stim_q.pop_back());
        if (v.hdr_dibits == 12) begin
            for (int k = 0; k < v.n_pix; k++) push_byte(v.pix);
            for (int k = 0; k < v.part_dibits; k++) stim_q.push_back(v.pix[2*k +: 2]);
            if (v.n_aud > 0) push_byte(v.aud0);
            if (v.n_aud > 1) push_byte(v.aud1);
            for (int k = 0; k < v.tail; k++) stim_q.push_back(2'b11);
        end
        send_q();
        idle(5);
        check({v.name, ".we_count"}, we_cnt, v.exp_we);
        if (v.exp_we > 0) begin
            check({v.name, ".first_addr"}, first_addr, v.exp_first);
            check({v.name, ".last_addr"}, last_addr, v.exp_last);
            check({v.name, ".addr_seq"}, seq_err, 0);
            check({v.name, ".data"}, data_err, 0);
            check({v.name, ".max_addr_lt_frame"}, longint'(max_addr < FP), 1);
        end
        check({v.name, ".done"}, done_cnt, v.exp_done);
        check({v.name, ".err"}, err_cnt, v.exp_err);
        check({v.name, ".aud_count"}, aud_q.size(), v.exp_aud);
        if (v.exp_aud > 0 && aud_q.size() > 0) check({v.name, ".aud0"}, aud_q[0], v.aud0);
        if (v.exp_aud > 1 && aud_q.size() > 1) check({v.name, ".aud1"}, aud_q[1], v.aud1);
    endtask

    initial begin
        //          name            base         hdr  pix  part pix   aud aud0   aud1   tail  we   first  last   done err aud
        vecs[0] = '{"base320",      24'h000140,  12,  320, 0,   8'hA5, 0, 8'h00, 8'h00, 0,    320, 320,   639,   1,   0,  0};
        vecs[1] = '{"wrap76700",    24'h012B9C,  12,  320, 0,   8'h5A, 0, 8'h00, 8'h00, 0,    320, 76700, 219,   1,   0,  0};
        vecs[2] = '{"illegal76800", 24'h012C00,  12,  320, 0,   8'hC3, 0, 8'h00, 8'h00, 0,    0,   0,     0,     0,   1,  0};
        vecs[3] = '{"short10",      24'd1000,    12,  10,  2,   8'h33, 0, 8'h00, 8'h00, 0,    10,  1000,  1009,  0,   1,  0};
        vecs[4] = '{"audio2",       24'd0,       12,  320, 0,   8'h81, 2, 8'h3C, 8'hFF, 2,    320, 0,     319,   1,   0,  2};
        vecs[5] = '{"edge76799",    24'd76799,   12,  320, 0,   8'h7E, 0, 8'h00, 8'h00, 0,    320, 76799, 318,   1,   0,  0};
        vecs[6] = '{"hdr_trunc",    24'd5,       5,   0,   0,   8'h00, 0, 8'h00, 8'h00, 0,    0,   0,     0,     0,   1,  0};
        vecs[7] = '{"hdr_ffffff",   24'hFFFFFF,  12,  4,   0,   8'h11, 0, 8'h00, 8'h00, 0,    0,   0,     0,     0,   1,  0};
        vecs[8] = '{"audio_part",   24'd100,     12,  320, 0,   8'h96, 1, 8'h69, 8'h00, 3,    320, 100,   419,   1,   0,  1};

        rst   = 1'b0;
        axiiv = 1'b0;
        axiid = 2'b00;
        chk_data = 1'b0;
        clear_mon();
        repeat (3) @(negedge clk);
        check("reset_outputs",
              {pixel_we, pixel_addr, pixel_data, audio_valid, audio_data, pkt_done, pkt_err}, 0);
        rst = 1'b1;
        idle(3);

        // First-pixel latency: strobe appears right after the 4th dibit is sampled
        clear_mon();
        push_byte(8'h00); push_byte(8'h00); push_byte(8'h02);
        send_q();
        send_dibit(2'b00); send_dibit(2'b01); send_dibit(2'b10);
        @(posedge clk); #2;
        check("lat_pre_we", pixel_we, 0);
        send_dibit(2'b11);
        @(posedge clk); #2;
        check("lat_we", pixel_we, 1);
        check("lat_addr", pixel_addr, 2);
        check("lat_data", pixel_data, 8'hE4);

        // Reset in the middle of pixel 100
        for (int k = 1; k < 100; k++) push_byte(8'h5A);
        stim_q.push_back(2'b10); stim_q.push_back(2'b10);
        send_q();
        @(negedge clk);
        check("pre_rst_we_count", we_cnt, 100);
        check("pre_rst_addr", pixel_addr, 101);
        rst = 1'b0;
        #1;
        check("rst_outputs_immediate",
              {pixel_we, pixel_addr, pixel_data, audio_valid, audio_data, pkt_done, pkt_err}, 0);
        clear_mon();
        send_dibit(2'b01); send_dibit(2'b01);
        @(negedge clk);
        rst = 1'b1;
        for (int k = 0; k < 40; k++) send_dibit(2'b01);
        idle(4);
        check("post_rst_we", we_cnt, 0);
        check("post_rst_done", done_cnt, 0);
        check("post_rst_err", err_cnt, 0);
        check("post_rst_aud", aud_q.size(), 0);

        foreach (vecs[i]) begin
            run_vec(vecs[i]);
            idle(2);
        end

        check("no_strobe_conflict", conflict_cnt, 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
